// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - access codes, FSM states and decode helpers for mem_access_unit
package mem_access_unit_pkg;

    localparam logic [3:0] MEM_LW  = 4'b0000;
    localparam logic [3:0] MEM_LH  = 4'b0001;
    localparam logic [3:0] MEM_LB  = 4'b0010;
    localparam logic [3:0] MEM_LHU = 4'b0011;
    localparam logic [3:0] MEM_LBU = 4'b0100;
    localparam logic [3:0] MEM_SW  = 4'b1000;
    localparam logic [3:0] MEM_SH  = 4'b1001;
    localparam logic [3:0] MEM_SB  = 4'b1010;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_WORD = 4'b1111;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_BYTE = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mau_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } mem_size_e;

    function automatic mem_size_e code_size(input logic [3:0] code);
        case (code)
            MEM_LW, MEM_SW:          return SZ_WORD;
            MEM_LH, MEM_LHU, MEM_SH: return SZ_HALF;
            MEM_LB, MEM_LBU, MEM_SB: return SZ_BYTE;
            default:                 return SZ_NONE;
        endcase
    endfunction

    function automatic logic code_legal(input logic [3:0] code);
        return code_size(code) != SZ_NONE;
    endfunction

    function automatic logic code_store(input logic [3:0] code);
        return (code == MEM_SW) || (code == MEM_SH) || (code == MEM_SB);
    endfunction

    function automatic logic misaligned(input logic [3:0] code, input logic [1:0] lo);
        case (code_size(code))
            SZ_WORD: return lo != 2'b00;
            SZ_HALF: return lo[0];
            default: return 1'b0;
        endcase
    endfunction

    // Drops the low address bits that a word/half access cannot use.
    function automatic logic [1:0] natural_lo(input logic [3:0] code, input logic [1:0] lo);
        case (code_size(code))
            SZ_WORD: return 2'b00;
            SZ_HALF: return {lo[1], 1'b0};
            default: return lo;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - CPU-side and data-memory-side bus interfaces of mem_access_unit
interface mem_cpu_if #(parameter int ADDR_W = 32);
    logic              cpu_req_valid;
    logic              cpu_req_ready;
    logic [3:0]        cpu_mem_rw;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_resp_valid;
    logic [31:0]       cpu_rdata;
    logic              cpu_err;

    modport master (output cpu_req_valid, cpu_mem_rw, cpu_addr, cpu_wdata,
                    input  cpu_req_ready, cpu_resp_valid, cpu_rdata, cpu_err);
    modport slave  (input  cpu_req_valid, cpu_mem_rw, cpu_addr, cpu_wdata,
                    output cpu_req_ready, cpu_resp_valid, cpu_rdata, cpu_err);
endinterface

interface mem_dmem_if #(parameter int ADDR_W = 32);
    logic              dmem_req_valid;
    logic              dmem_req_ready;
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_we;
    logic [3:0]        dmem_wstrb;
    logic [31:0]       dmem_wdata;
    logic              dmem_resp_valid;
    logic [31:0]       dmem_rdata;

    modport master (output dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
                    input  dmem_req_ready, dmem_resp_valid, dmem_rdata);
    modport slave  (input  dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
                    output dmem_req_ready, dmem_resp_valid, dmem_rdata);
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// rtl/mem_access_unit_lane_align.sv - combinational store lane replication/strobes and load shift/extend
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [3:0]  code,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] lane;

    always_comb begin
        lane      = rdata >> {addr_lo, 3'b000};
        wstrb     = STRB_NONE;
        wdata_rep = wdata;
        rdata_ext = lane;
        case (code)
            MEM_SW:  wstrb = STRB_WORD;
            MEM_SH: begin
                wstrb     = STRB_HALF << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            MEM_SB: begin
                wstrb     = STRB_BYTE << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            MEM_LB:  rdata_ext = {{24{lane[7]}}, lane[7:0]};
            MEM_LBU: rdata_ext = {24'd0, lane[7:0]};
            MEM_LH:  rdata_ext = {{16{lane[15]}}, lane[15:0]};
            MEM_LHU: rdata_ext = {16'd0, lane[15:0]};
            default: rdata_ext = lane;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - CPU load/store unit; MEM_ACCESS_MISALIGN_TRAP_EN traps misaligned accesses
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic        clk,
    input  logic        resetn,
    mem_cpu_if.slave    cpu,
    mem_dmem_if.master  dmem
);

    mau_state_e        state_q, state_d;
    logic [3:0]        code_q;
    logic [1:0]        lo_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              accept;
    logic              req_err;
    logic [1:0]        eff_lo;
    logic [3:0]        sel_code;
    logic [1:0]        sel_lo;
    logic [3:0]        wstrb_c;
    logic [31:0]       wdata_c;
    logic [31:0]       rdata_c;

    assign accept = cpu.cpu_req_valid && (state_q == ST_IDLE);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign req_err = !code_legal(cpu.cpu_mem_rw) || misaligned(cpu.cpu_mem_rw, cpu.cpu_addr[1:0]);
    assign eff_lo  = cpu.cpu_addr[1:0];
`else
    assign req_err = !code_legal(cpu.cpu_mem_rw);
    assign eff_lo  = natural_lo(cpu.cpu_mem_rw, cpu.cpu_addr[1:0]);
`endif

    // The aligner serves the incoming store in IDLE and the captured load afterwards.
    assign sel_code = (state_q == ST_IDLE) ? cpu.cpu_mem_rw : code_q;
    assign sel_lo   = (state_q == ST_IDLE) ? eff_lo : lo_q;

    mem_lane_align u_align (
        .code      (sel_code),
        .addr_lo   (sel_lo),
        .wdata     (cpu.cpu_wdata),
        .rdata     (dmem.dmem_rdata),
        .wstrb     (wstrb_c),
        .wdata_rep (wdata_c),
        .rdata_ext (rdata_c)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = req_err ? ST_DONE : ST_REQ;
            ST_REQ:  if (dmem.dmem_req_ready) state_d = code_store(code_q) ? ST_DONE : ST_WAIT;
            ST_WAIT: if (dmem.dmem_resp_valid) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            code_q  <= MEM_LW;
            lo_q    <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wstrb_q <= STRB_NONE;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                code_q  <= cpu.cpu_mem_rw;
                lo_q    <= eff_lo;
                rdata_q <= '0;
                err_q   <= req_err;
                if (!req_err) begin
                    addr_q  <= {cpu.cpu_addr[ADDR_W-1:2], 2'b00};
                    we_q    <= code_store(cpu.cpu_mem_rw);
                    wstrb_q <= wstrb_c;
                    wdata_q <= wdata_c;
                end
            end
            if ((state_q == ST_WAIT) && dmem.dmem_resp_valid) begin
                rdata_q <= rdata_c;
            end
        end
    end

    assign cpu.cpu_req_ready   = (state_q == ST_IDLE);
    assign cpu.cpu_resp_valid  = (state_q == ST_DONE);
    assign cpu.cpu_rdata       = rdata_q;
    assign cpu.cpu_err         = err_q;
    assign dmem.dmem_req_valid = (state_q == ST_REQ);
    assign dmem.dmem_addr      = addr_q;
    assign dmem.dmem_we        = we_q;
    assign dmem.dmem_wstrb     = wstrb_q;
    assign dmem.dmem_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed vector bench for mem_access_unit
module tb_mem_access_unit;

    logic clk;
    logic resetn;
    int   total;
    int   bad;

    mem_cpu_if  #(.ADDR_W(32)) cpu_bus ();
    mem_dmem_if #(.ADDR_W(32)) dmem_bus ();

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .cpu    (cpu_bus),
        .dmem   (dmem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  code;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
        logic        exp_mem;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input string name, input logic [3:0] code, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata, input int dly,
                                 input logic exp_mem, input logic [31:0] exp_addr, input logic exp_we,
                                 input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.name = name; v.code = code; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.dly = dly;
        v.exp_mem = exp_mem; v.exp_addr = exp_addr; v.exp_we = exp_we; v.exp_wstrb = exp_wstrb;
        v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    // dly: cycles of dmem_req_ready low for stores, cycles in WAIT before the response for loads.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        cpu_bus.cpu_req_valid = 1'b1;
        cpu_bus.cpu_mem_rw    = v.code;
        cpu_bus.cpu_addr      = v.addr;
        cpu_bus.cpu_wdata     = v.wdata;
        @(negedge clk);
        cpu_bus.cpu_req_valid = 1'b0;
        chk({v.name, ":dmem_req_valid"}, 32'(dmem_bus.dmem_req_valid), 32'(v.exp_mem));
        if (v.exp_mem) begin
            for (int i = 0; i < (v.exp_we ? v.dly : 0); i++) begin
                chk({v.name, ":stall_req_valid"}, 32'(dmem_bus.dmem_req_valid), 32'd1);
                chk({v.name, ":stall_cpu_ready"}, 32'(cpu_bus.cpu_req_ready), 32'd0);
                chk({v.name, ":stall_addr"}, dmem_bus.dmem_addr, v.exp_addr);
                chk({v.name, ":stall_wdata"}, dmem_bus.dmem_wdata, v.exp_wdata);
                @(negedge clk);
            end
            chk({v.name, ":dmem_addr"}, dmem_bus.dmem_addr, v.exp_addr);
            chk({v.name, ":dmem_we"}, 32'(dmem_bus.dmem_we), 32'(v.exp_we));
            chk({v.name, ":dmem_wstrb"}, 32'(dmem_bus.dmem_wstrb), 32'(v.exp_wstrb));
            if (v.exp_we) chk({v.name, ":dmem_wdata"}, dmem_bus.dmem_wdata, v.exp_wdata);
            dmem_bus.dmem_req_ready = 1'b1;
            @(negedge clk);
            dmem_bus.dmem_req_ready = 1'b0;
            if (!v.exp_we) begin
                for (int i = 0; i < v.dly; i++) begin
                    chk({v.name, ":early_resp"}, 32'(cpu_bus.cpu_resp_valid), 32'd0);
                    @(negedge clk);
                end
                dmem_bus.dmem_resp_valid = 1'b1;
                dmem_bus.dmem_rdata      = v.rdata;
                @(negedge clk);
                dmem_bus.dmem_resp_valid = 1'b0;
                dmem_bus.dmem_rdata      = '0;
            end
        end
        chk({v.name, ":resp_valid"}, 32'(cpu_bus.cpu_resp_valid), 32'd1);
        chk({v.name, ":rdata"}, cpu_bus.cpu_rdata, v.exp_rdata);
        chk({v.name, ":err"}, 32'(cpu_bus.cpu_err), 32'(v.exp_err));
        @(negedge clk);
        chk({v.name, ":resp_pulse_end"}, 32'(cpu_bus.cpu_resp_valid), 32'd0);
        chk({v.name, ":ready_again"}, 32'(cpu_bus.cpu_req_ready), 32'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        resetn = 1'b0;
        cpu_bus.cpu_req_valid    = 1'b0;
        cpu_bus.cpu_mem_rw       = 4'b0000;
        cpu_bus.cpu_addr         = '0;
        cpu_bus.cpu_wdata        = '0;
        dmem_bus.dmem_req_ready  = 1'b0;
        dmem_bus.dmem_resp_valid = 1'b0;
        dmem_bus.dmem_rdata      = '0;

        vecs.push_back(mkv("sb_1003", 4'b1010, 32'h1003, 32'h000000AB, 32'h0, 0,
                           1, 32'h1000, 1, 4'b1000, 32'hABABABAB, 32'h0, 0));
        vecs.push_back(mkv("lb_2002", 4'b0010, 32'h2002, 32'h0, 32'h1280FF34, 3,
                           1, 32'h2000, 0, 4'b0000, 32'h0, 32'hFFFFFF80, 0));
        vecs.push_back(mkv("lbu_2002", 4'b0100, 32'h2002, 32'h0, 32'h1280FF34, 3,
                           1, 32'h2000, 0, 4'b0000, 32'h0, 32'h00000080, 0));
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        vecs.push_back(mkv("lh_2001", 4'b0001, 32'h2001, 32'h0, 32'h1280FF34, 0,
                           0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1));
        vecs.push_back(mkv("sw_5001", 4'b1000, 32'h5001, 32'h11223344, 32'h0, 0,
                           0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1));
`else
        vecs.push_back(mkv("lh_2001", 4'b0001, 32'h2001, 32'h0, 32'h1280FF34, 0,
                           1, 32'h2000, 0, 4'b0000, 32'h0, 32'hFFFFFF34, 0));
        vecs.push_back(mkv("sw_5001", 4'b1000, 32'h5001, 32'h11223344, 32'h0, 0,
                           1, 32'h5000, 1, 4'b1111, 32'h11223344, 32'h0, 0));
`endif
        vecs.push_back(mkv("ill_0111", 4'b0111, 32'h3000, 32'h0, 32'h0, 0,
                           0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1));
        vecs.push_back(mkv("sw_stall4", 4'b1000, 32'h3000, 32'hDEADBEEF, 32'h0, 4,
                           1, 32'h3000, 1, 4'b1111, 32'hDEADBEEF, 32'h0, 0));
        vecs.push_back(mkv("sh_3002", 4'b1001, 32'h3002, 32'h1234CAFE, 32'h0, 1,
                           1, 32'h3000, 1, 4'b1100, 32'hCAFECAFE, 32'h0, 0));
        vecs.push_back(mkv("sb_1001", 4'b1010, 32'h1001, 32'h0000005A, 32'h0, 0,
                           1, 32'h1000, 1, 4'b0010, 32'h5A5A5A5A, 32'h0, 0));
        vecs.push_back(mkv("lhu_4002", 4'b0011, 32'h4002, 32'h0, 32'h80017FFF, 1,
                           1, 32'h4000, 0, 4'b0000, 32'h0, 32'h00008001, 0));
        vecs.push_back(mkv("lh_4002", 4'b0001, 32'h4002, 32'h0, 32'h80017FFF, 0,
                           1, 32'h4000, 0, 4'b0000, 32'h0, 32'hFFFF8001, 0));
        vecs.push_back(mkv("lw_4004", 4'b0000, 32'h4004, 32'h0, 32'hA5A55A5A, 0,
                           1, 32'h4004, 0, 4'b0000, 32'h0, 32'hA5A55A5A, 0));
        vecs.push_back(mkv("lb_6001", 4'b0010, 32'h6001, 32'h0, 32'h11227F33, 2,
                           1, 32'h6000, 0, 4'b0000, 32'h0, 32'h0000007F, 0));
        vecs.push_back(mkv("ill_1111", 4'b1111, 32'h6000, 32'hFFFFFFFF, 32'h0, 0,
                           0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1));

        repeat (2) @(negedge clk);
        chk("rst:cpu_req_ready", 32'(cpu_bus.cpu_req_ready), 32'd1);
        chk("rst:cpu_resp_valid", 32'(cpu_bus.cpu_resp_valid), 32'd0);
        chk("rst:cpu_err", 32'(cpu_bus.cpu_err), 32'd0);
        chk("rst:cpu_rdata", cpu_bus.cpu_rdata, 32'd0);
        chk("rst:dmem_req_valid", 32'(dmem_bus.dmem_req_valid), 32'd0);
        chk("rst:dmem_we", 32'(dmem_bus.dmem_we), 32'd0);
        chk("rst:dmem_addr", dmem_bus.dmem_addr, 32'd0);
        chk("rst:dmem_wstrb", 32'(dmem_bus.dmem_wstrb), 32'd0);
        chk("rst:dmem_wdata", dmem_bus.dmem_wdata, 32'd0);
        resetn = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // A response arriving with the acceptance must not complete the load.
        @(negedge clk);
        cpu_bus.cpu_req_valid = 1'b1;
        cpu_bus.cpu_mem_rw    = 4'b0000;
        cpu_bus.cpu_addr      = 32'h8000;
        @(negedge clk);
        cpu_bus.cpu_req_valid    = 1'b0;
        dmem_bus.dmem_req_ready  = 1'b1;
        dmem_bus.dmem_resp_valid = 1'b1;
        dmem_bus.dmem_rdata      = 32'hBAD0BAD0;
        @(negedge clk);
        dmem_bus.dmem_req_ready  = 1'b0;
        dmem_bus.dmem_resp_valid = 1'b0;
        chk("early:no_resp", 32'(cpu_bus.cpu_resp_valid), 32'd0);
        dmem_bus.dmem_resp_valid = 1'b1;
        dmem_bus.dmem_rdata      = 32'h600DF00D;
        @(negedge clk);
        dmem_bus.dmem_resp_valid = 1'b0;
        chk("early:resp_valid", 32'(cpu_bus.cpu_resp_valid), 32'd1);
        chk("early:rdata", cpu_bus.cpu_rdata, 32'h600DF00D);

        // Reset while waiting for load data, then a stale response.
        @(negedge clk);
        cpu_bus.cpu_req_valid = 1'b1;
        cpu_bus.cpu_mem_rw    = 4'b0000;
        cpu_bus.cpu_addr      = 32'h7000;
        @(negedge clk);
        cpu_bus.cpu_req_valid   = 1'b0;
        dmem_bus.dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_bus.dmem_req_ready = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("rstwait:cpu_resp_valid", 32'(cpu_bus.cpu_resp_valid), 32'd0);
        chk("rstwait:cpu_req_ready", 32'(cpu_bus.cpu_req_ready), 32'd1);
        chk("rstwait:dmem_addr", dmem_bus.dmem_addr, 32'd0);
        chk("rstwait:dmem_req_valid", 32'(dmem_bus.dmem_req_valid), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        dmem_bus.dmem_resp_valid = 1'b1;
        dmem_bus.dmem_rdata      = 32'hFFFFFFFF;
        @(negedge clk);
        dmem_bus.dmem_resp_valid = 1'b0;
        chk("rstwait:late_resp", 32'(cpu_bus.cpu_resp_valid), 32'd0);
        @(negedge clk);
        chk("rstwait:late_resp2", 32'(cpu_bus.cpu_resp_valid), 32'd0);
        chk("rstwait:rdata", cpu_bus.cpu_rdata, 32'd0);
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
